exe_mem_stage: RTL and testbench
================================

# exe_mem_stage

Execute stage plus EXE/MEM pipeline register of the 5-stage pipelined CPU. Consumes the ID/EXE register outputs, computes the ALU or JAL link result, selects the destination register, and registers everything into the MEM-stage signals. An optional 32-cycle iterative multiplier stalls the front of the pipeline through `estall` while it runs.

## Interface

Parameters: none; widths are fixed at 32-bit data and 5-bit register numbers.

- `clk` in 1: sole clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ewreg`, `em2reg`, `ewmem` in 1: register-write, load-select and memory-write controls from ID/EXE.
- `ejal` in 1: jump-and-link.
- `eshift` in 1: operand A = shift amount `eimm[10:6]`.
- `ealuimm` in 1: operand B = `eimm`.
- `ealuc` in 4: ALU operation code.
- `epc4`, `eimm`, `ea`, `eb` in 32: PC+4, extended immediate, and register operands.
- `ern` in 5: destination register number.
- `ealu` out 32: combinational EXE result, forwarded to ID.
- `estall` out 1: hold PC, IF/ID and ID/EXE this cycle.
- `mwreg`, `mm2reg`, `mwmem` out 1: registered controls.
- `malu`, `mb` out 32: registered result and store data (`eb`).
- `mrn` out 5: registered destination.

## Operation

- Operands: `a = eshift ? {27'b0, eimm[10:6]} : ea`; `b = ealuimm ? eimm : eb`.
- `ealuc` decode:
  - x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR; ADD/SUB wrap mod 2^32, no overflow trap.
  - x110 LUI: `b << 16`.
  - 0011 SLL: `b << a[4:0]`. 0111 SRL: logical right. 1111 SRA: arithmetic right.
  - 1011 MUL: low 32 bits of `ea*eb`, unsigned shift-add.
- Result and destination: `ealu = ejal ? epc4 + 4 : alu_result`; destination = `ejal ? 5'd31 : ern`.
- Multiplier FSM, states IDLE and BUSY, with a 5-bit counter `cnt`:
  - IDLE with `ealuc==1011` → BUSY. Latches multiplicand/multiplier; product = 0; `cnt` = 0.
  - BUSY: one shift-add per cycle, `cnt` increments.
  - BUSY with `cnt==31` → IDLE. The final partial sum is written straight into `malu`.
- `estall = !rst && ((IDLE && mul_op) || (BUSY && cnt != 31))`.
- While `estall` is high the register loads a bubble: `mwreg`, `mm2reg`, `mwmem` = 0, `malu`/`mb`/`mrn` = 0. Inputs are held stable by upstream.

## Timing

- Non-MUL instructions: one cycle. Inputs valid in cycle t appear on the `m*` outputs after the posedge ending t.
- `ealu`: combinational, same cycle as its inputs.
- MUL:
  - Occupies EXE for 33 cycles; `estall` is high for the first 32.
  - Product appears on `malu` after the 33rd posedge, together with `mwreg=ewreg` and `mrn`.
  - `ealu` is not valid for MUL; ID must not forward it during a stall.
- Reset:
  - All `m*` outputs = 0; FSM = IDLE, `cnt` = 0.
  - `estall` is forced 0 during the reset cycle.
  - Reset in BUSY aborts the multiply with no writeback.
- MUL immediately following MUL: the second is detected in the IDLE cycle after the first completes; no gap needed.
- JAL with `ealuc==1011`: `ejal` wins. No multiply starts; result is `epc4+4`.

## Configuration

- `EXE_MUL_EN` defined: multiplier FSM and stall logic are built as above.
- Undefined:
  - No FSM; `estall` is constant 0.
  - `ealuc==1011` yields `alu_result = 32'h0`, single cycle.
  - All other codes are unchanged.

## Structure

- Shared package `cpu_pkg`:
  - ALU code constants (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_LUI`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_MUL`).
  - Multiplier state enum.
  - `REG_RA = 5'd31`.
- One sub-module, `seq_mul`: iterative 32×32→32 multiplier with start/busy/last/product signals, instantiated only under `EXE_MUL_EN`.

## Test plan

- ADD: `ea=7`, `eb=5`, `ealuc=0000`, `ewreg=1`, `ern=3` → next cycle `malu=12`, `mrn=3`, `mwreg=1`, `estall=0`.
- SRA and LUI:
  - `eshift=1`, `eimm[10:6]=4`, `eb=32'h80000000`, `ealuc=1111` → `malu=32'hF8000000`.
  - LUI with `eimm=32'h1234` → `malu=32'h12340000`.
- JAL: `ejal=1`, `epc4=32'h100`, `ern=0` → `malu=32'h104`, `mrn=31`.
- MUL, with `EXE_MUL_EN`:
  - `ea=123456`, `eb=789` → `estall` high exactly 32 cycles, bubbles on `m*` meanwhile.
  - Then `malu=97406784` with `mwreg=1`.
  - Without the macro: `malu=0` after 1 cycle, `estall` never high.
- Reset mid-MUL: assert `rst` in the 10th BUSY cycle → next cycle all `m*`=0, `estall=0`, IDLE; following ADD completes in one cycle.
- Back-to-back MUL then SUB: `5*6` then `9-4` → `malu=30`, then `malu=5` on the next cycle, no extra stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: ALU operation codes, the
// multiplier state encoding and fixed architectural register numbers.
package cpu_pkg;

    // ALU operation codes; bit 3 only matters for the shift/multiply group.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_MUL = 4'b1011;

    // Link register written by jump-and-link.
    localparam logic [4:0] REG_RA = 5'd31;

    // Iterative multiplier states.
    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative 32x32->32 shift-add multiplier, one partial product per cycle.
// 'product' is the running sum including the current step, so in the cycle
// where 'last' is high it already holds the complete low 32-bit result.
module seq_mul
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand_in,
    input  logic [31:0] mplier_in,
    output logic        busy,
    output logic        last,
    output logic [31:0] product
);

    mul_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] partial;

    assign partial = mplier[0] ? mcand : 32'h0;
    assign product = acc + partial;
    assign busy    = (state == MUL_BUSY);
    assign last    = busy && (cnt == 5'd31);

    // Multiplier FSM: latch operands on start, then 32 shift-add steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MUL_IDLE;
            cnt    <= 5'd0;
            mcand  <= 32'h0;
            mplier <= 32'h0;
            acc    <= 32'h0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        state  <= MUL_BUSY;
                        mcand  <= mcand_in;
                        mplier <= mplier_in;
                        acc    <= 32'h0;
                        cnt    <= 5'd0;
                    end
                end
                MUL_BUSY: begin
                    acc    <= product;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= MUL_IDLE;
                    end
                end
                default: begin
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage and EXE/MEM pipeline register of the 5-stage CPU.
// Optional feature macro: EXE_MUL_EN builds the 32-cycle iterative
// multiplier and its front-end stall; without it MUL produces 0 in one cycle.
module exe_mem_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic        ejal,
    input  logic        eshift,
    input  logic        ealuimm,
    input  logic [3:0]  ealuc,
    input  logic [31:0] epc4,
    input  logic [31:0] eimm,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic        estall,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn
);

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        mul_done;
    logic [31:0] mul_product;

    assign a    = eshift ? {27'b0, eimm[10:6]} : ea;
    assign b    = ealuimm ? eimm : eb;
    assign ealu = ejal ? (epc4 + 32'd4) : alu_result;
    assign dest = ejal ? REG_RA : ern;

    // ALU: decode on the low three bits, bit 3 splits SLL/MUL and SRL/SRA.
    always_comb begin
        alu_result = 32'h0;
        case (ealuc[2:0])
            ALU_ADD[2:0]: alu_result = a + b;
            ALU_SUB[2:0]: alu_result = a - b;
            ALU_AND[2:0]: alu_result = a & b;
            ALU_OR[2:0]:  alu_result = a | b;
            ALU_XOR[2:0]: alu_result = a ^ b;
            ALU_LUI[2:0]: alu_result = b << 16;
            ALU_SLL[2:0]: begin
                // MUL shares this slot; its result comes from the multiplier.
                if (ealuc[3]) begin
                    alu_result = 32'h0;
                end else begin
                    alu_result = b << a[4:0];
                end
            end
            ALU_SRL[2:0]: begin
                if (ealuc[3]) begin
                    alu_result = $signed(b) >>> a[4:0];
                end else begin
                    alu_result = b >> a[4:0];
                end
            end
            default: alu_result = 32'h0;
        endcase
    end

`ifdef EXE_MUL_EN
    logic mul_op;
    logic mul_busy;
    logic mul_last;

    // A jump-and-link never starts a multiply, whatever its ALU code.
    assign mul_op = !ejal && (ealuc == ALU_MUL);

    seq_mul u_seq_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_op),
        .mcand_in  (ea),
        .mplier_in (eb),
        .busy      (mul_busy),
        .last      (mul_last),
        .product   (mul_product)
    );

    assign estall   = !rst && ((!mul_busy && mul_op) || (mul_busy && !mul_last));
    assign mul_done = mul_last;
`else
    assign estall      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = 32'h0;
`endif

    // EXE/MEM register: bubble while stalled, multiplier result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            malu   <= 32'h0;
            mb     <= 32'h0;
            mrn    <= 5'd0;
        end else if (estall) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            malu   <= 32'h0;
            mb     <= 32'h0;
            mrn    <= 5'd0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            malu   <= mul_done ? mul_product : ealu;
            mb     <= eb;
            mrn    <= dest;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed self-checking bench for exe_mem_stage (both EXE_MUL_EN builds).
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ewreg, em2reg, ewmem, ejal, eshift, ealuimm;
    logic [3:0]  ealuc;
    logic [31:0] epc4, eimm, ea, eb;
    logic [4:0]  ern;
    logic [31:0] ealu;
    logic        estall;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;

    int checks = 0;
    int errors = 0;
    int stalls;
    logic bubble_bad;

    exe_mem_stage dut (
        .clk(clk), .rst(rst),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ejal(ejal), .eshift(eshift), .ealuimm(ealuimm),
        .ealuc(ealuc), .epc4(epc4), .eimm(eimm), .ea(ea), .eb(eb),
        .ern(ern), .ealu(ealu), .estall(estall),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic set_op(input logic [3:0] aluc, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] imm_v, input logic sh_v, input logic imm_sel,
                          input logic [4:0] rn_v);
        ealuc   = aluc;
        ea      = a_v;
        eb      = b_v;
        eimm    = imm_v;
        eshift  = sh_v;
        ealuimm = imm_sel;
        ern     = rn_v;
        ejal    = 1'b0;
        ewreg   = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait out a multiply stall, counting stalled cycles and checking bubbles.
    task automatic wait_stall;
        stalls     = 0;
        bubble_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!estall) break;
            stalls++;
            tick();
            if (malu !== 32'h0 || mwreg !== 1'b0 || mrn !== 5'd0 || mb !== 32'h0) bubble_bad = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; em2reg = 1'b0; ewmem = 1'b0; epc4 = 32'h0;
        set_op(4'b0000, 32'd7, 32'd5, 32'h0, 1'b0, 1'b0, 5'd3);
        #1;
        chk("reset_estall", {31'b0, estall}, 32'd0);
        tick();
        chk("reset_malu", malu, 32'h0);
        chk("reset_mwreg", {31'b0, mwreg}, 32'd0);
        chk("reset_mrn", {27'b0, mrn}, 32'd0);
        chk("reset_mb", mb, 32'h0);
        rst = 1'b0;

        // ADD 7+5
        set_op(4'b0000, 32'd7, 32'd5, 32'h0, 1'b0, 1'b0, 5'd3);
        #1;
        chk("add_ealu", ealu, 32'd12);
        chk("add_estall", {31'b0, estall}, 32'd0);
        tick();
        chk("add_malu", malu, 32'd12);
        chk("add_mrn", {27'b0, mrn}, 32'd3);
        chk("add_mwreg", {31'b0, mwreg}, 32'd1);
        chk("add_mb", mb, 32'd5);

        // SRA by shift amount 4 from eimm[10:6]
        set_op(4'b1111, 32'h0, 32'h8000_0000, 32'h0000_0100, 1'b1, 1'b0, 5'd4);
        tick();
        chk("sra_malu", malu, 32'hF800_0000);

        // LUI with load/store controls passed through
        set_op(4'b0110, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b1, 5'd6);
        em2reg = 1'b1; ewmem = 1'b1;
        tick();
        chk("lui_malu", malu, 32'h1234_0000);
        chk("lui_mm2reg", {31'b0, mm2reg}, 32'd1);
        chk("lui_mwmem", {31'b0, mwmem}, 32'd1);
        em2reg = 1'b0; ewmem = 1'b0;

        // SLL 1 << 4 and SRL 0x80000000 >> 4
        set_op(4'b0011, 32'd4, 32'd1, 32'h0, 1'b0, 1'b0, 5'd7);
        tick();
        chk("sll_malu", malu, 32'd16);
        set_op(4'b0111, 32'd4, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 5'd7);
        tick();
        chk("srl_malu", malu, 32'h0800_0000);

        // JAL carrying the MUL code: jump wins, no multiply
        set_op(4'b1011, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0, 5'd0);
        ejal = 1'b1; epc4 = 32'h100;
        #1;
        chk("jal_estall", {31'b0, estall}, 32'd0);
        tick();
        chk("jal_malu", malu, 32'h104);
        chk("jal_mrn", {27'b0, mrn}, 32'd31);
        ejal = 1'b0;

        // MUL 123456 * 789
        set_op(4'b1011, 32'd123456, 32'd789, 32'h0, 1'b0, 1'b0, 5'd9);
        #1;
`ifdef EXE_MUL_EN
        wait_stall();
        chk("mul_stall_cycles", stalls, 32'd32);
        chk("mul_bubbles", {31'b0, bubble_bad}, 32'd0);
        tick();
        chk("mul_malu", malu, 32'd97406784);
        chk("mul_mwreg", {31'b0, mwreg}, 32'd1);
        chk("mul_mrn", {27'b0, mrn}, 32'd9);
`else
        chk("mul_estall", {31'b0, estall}, 32'd0);
        tick();
        chk("mul_malu", malu, 32'h0);
        chk("mul_mwreg", {31'b0, mwreg}, 32'd1);
`endif

`ifdef EXE_MUL_EN
        // Reset during the 10th BUSY cycle aborts the multiply
        set_op(4'b1011, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 5'd8);
        repeat (10) tick();
        chk("abort_busy_estall", {31'b0, estall}, 32'd1);
        rst = 1'b1;
        set_op(4'b0000, 32'd7, 32'd5, 32'h0, 1'b0, 1'b0, 5'd3);
        #1;
        chk("abort_rst_estall", {31'b0, estall}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_malu", malu, 32'h0);
        chk("abort_mwreg", {31'b0, mwreg}, 32'd0);
        chk("abort_mrn", {27'b0, mrn}, 32'd0);
        chk("abort_estall_after", {31'b0, estall}, 32'd0);
        tick();
        chk("abort_add_malu", malu, 32'd12);
`endif

        // MUL 5*6 immediately followed by SUB 9-4
        set_op(4'b1011, 32'd5, 32'd6, 32'h0, 1'b0, 1'b0, 5'd10);
        #1;
`ifdef EXE_MUL_EN
        wait_stall();
        chk("b2b_stall_cycles", stalls, 32'd32);
`endif
        tick();
`ifdef EXE_MUL_EN
        chk("b2b_mul_malu", malu, 32'd30);
`else
        chk("b2b_mul_malu", malu, 32'h0);
`endif
        set_op(4'b0100, 32'd9, 32'd4, 32'h0, 1'b0, 1'b0, 5'd11);
        #1;
        chk("b2b_sub_estall", {31'b0, estall}, 32'd0);
        tick();
        chk("b2b_sub_malu", malu, 32'd5);
        chk("b2b_sub_mrn", {27'b0, mrn}, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
